// File: rtl/gated_xor_checker_if.sv
// Stimulus/response bundle between the vector source and gated_xor_checker.
// master drives vectors and reads the verdict; slave is the checker.
interface gated_xor_checker_if #(
  parameter int CW = 8
);
  logic          start;
  logic          in_valid;
  logic          en;
  logic          a;
  logic          b;
  logic          q;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] err_count;
  logic [CW-1:0] vec_count;
  logic [CW-1:0] first_fail_idx;
  logic          first_fail_valid;

  modport master (
    output start, in_valid, en, a, b, q,
    input  busy, done, pass, err_count,
    input  vec_count, first_fail_idx,
    input  first_fail_valid
  );

  modport slave (
    input  start, in_valid, en, a, b, q,
    output busy, done, pass, err_count,
    output vec_count, first_fail_idx,
    output first_fail_valid
  );
endinterface

// File: rtl/gated_xor_checker.sv
// Scores q against en ? a^b : 0 over a fixed-length run of vectors.
// CHECKER_HALT_ON_FAIL_EN: end the run at the first mismatch.
module gated_xor_checker #(
  parameter int NUM_VECTORS = 8,
  parameter int CW          = 8
) (
  input logic                 clk,
  input logic                 rst,
  gated_xor_checker_if.slave  bus
);

`ifdef CHECKER_HALT_ON_FAIL_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  localparam logic [CW-1:0] LAST = CW'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] err_count;
  logic [CW-1:0] vec_count;
  logic [CW-1:0] ff_idx;
  logic          ff_valid;

  logic exp_q;
  logic mis;

  assign exp_q = bus.en & (bus.a ^ bus.b);
  // Four-state compare so an X/Z response is scored as a failure.
  assign mis   = (bus.q !== exp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_count <= '0;
      ff_idx    <= '0;
      ff_valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
            ff_idx    <= '0;
            ff_valid  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            vec_count <= vec_count + 1'b1;
            if (mis) begin
              err_count <= err_count + 1'b1;
              if (!ff_valid) begin
                ff_idx   <= vec_count;
                ff_valid <= 1'b1;
              end
            end
            if (vec_count == LAST || (HALT && mis)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !mis && (err_count == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass             = pass;
  assign bus.err_count        = err_count;
  assign bus.vec_count        = vec_count;
  assign bus.first_fail_idx   = ff_idx;
  assign bus.first_fail_valid = ff_valid;

endmodule

// File: doc/gated_xor_checker.md
Name: gated_xor_checker

Overview:
- Self-checking response monitor for the enabled-XOR stage, whose function is q = en ? (a ^ b) : 0.
- Sits on the receiving end of the stimulus counter. It samples each applied {en,a,b} vector with the DUT's q, computes the expected value, and scores it.
- Runs a fixed-length test of NUM_VECTORS vectors, then reports pass/fail, the error count and the index of the first failing vector.
- Replaces printed-log inspection with a synthesizable, checkable verdict.

Parameters:
- NUM_VECTORS, 8: number of accepted vectors per run. Legal range 1 .. 2^CW-1.
- CW, 8: width of the vector counter, error counter and failure-index register.

Ports:
- clk  in  1: system clock; all logic is on the rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: one-cycle pulse that begins a run. Honoured in IDLE and DONE only.
- in_valid  in  1: en/a/b/q carry a vector this cycle.
- en  in  1: enable of the applied vector.
- a  in  1: operand a of the applied vector.
- b  in  1: operand b of the applied vector.
- q  in  1: DUT response for the same vector, same cycle.
- busy  out  1: high while in RUN.
- done  out  1: high while in DONE.
- pass  out  1: valid while done=1. High iff err_count==0.
- err_count  out  CW: number of mismatching vectors in the current or last run.
- vec_count  out  CW: number of vectors accepted in the current or last run.
- first_fail_idx  out  CW: vec_count value at the first mismatch (0-based index).
- first_fail_valid  out  1: first_fail_idx holds a captured value.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-run):
  - state goes to IDLE.
  - busy, done, pass, first_fail_valid are 0.
  - err_count, vec_count, first_fail_idx are 0.
  - Reset has priority over start and in_valid.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - in_valid is ignored.
  - start=1 -> RUN next cycle, with all counters and first-fail registers cleared on that same edge.
- RUN:
  - Expected value: exp = en ? (a ^ b) : 1'b0.
  - Mismatch test is q !== exp, so X or Z on q counts as a mismatch in simulation.
  - On each edge with in_valid=1:
    - vec_count increments by 1.
    - On a mismatch, err_count increments by 1.
    - On a mismatch with first_fail_valid=0: first_fail_idx <= current (pre-increment) vec_count and first_fail_valid <= 1.
  - Cycles with in_valid=0 change nothing; gaps of any length are legal.
  - When the accepted vector brings vec_count to NUM_VECTORS, the state becomes DONE on the same edge. done is high from the following cycle (1-cycle latency after the last vector's edge).
  - start is ignored while in RUN.
- DONE:
  - done=1, busy=0, pass=(err_count==0).
  - All counters hold; in_valid is ignored.
  - start=1 -> RUN with counters cleared (immediate re-run).
- Counter widths: err_count cannot exceed vec_count, so no overflow is possible within the legal NUM_VECTORS range. No saturation logic is required.
- Simultaneous start and in_valid in IDLE/DONE: the vector is not scored; scoring begins the cycle after entry to RUN.

Optional Feature:
- Macro: CHECKER_HALT_ON_FAIL_EN.
- Defined: the first mismatch in RUN ends the run. The state moves to DONE on that edge, the counters include the failing vector, and pass=0.
- Undefined: the run always completes all NUM_VECTORS vectors regardless of failures; mismatches are counted only.

Test Plan:
- Reset, start, then 8 consecutive vectors {en,a,b}=0..7 with a correct q (q=1 only for vectors 5 and 6) -> done=1 one cycle after the 8th accept; pass=1, err_count=0, vec_count=8, first_fail_valid=0.
- Same sequence, but vector 5 ({en,a,b}=101) is driven with q=0 and vector 2 with q=1 -> pass=0, err_count=2, first_fail_idx=2, first_fail_valid=1, vec_count=8.
- Correct vectors with in_valid toggling 1,0,1,0,... -> done asserts only after the 8th in_valid=1 cycle (about 16 cycles); vec_count=8.
- Assert rst after 3 accepted vectors -> next cycle busy=0, all counts 0. A new start with 8 correct vectors -> pass=1.
- start pulsed during RUN -> no effect, vec_count keeps counting. start in DONE -> counters clear and a new run completes normally.
- With CHECKER_HALT_ON_FAIL_EN, vector 3 ({en,a,b}=011) driven with q=1 -> done the next cycle, vec_count=4, err_count=1, first_fail_idx=3, pass=0. Without the macro, the run continues to vec_count=8.
